// File: rtl/picosoc_loader_pkg.sv
// Shared types and constants for the PicoSoC firmware loader.
// The readback states are present only when PICOSOC_MEM_LOADER_VERIFY_EN is defined.
package picosoc_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_FIELD_W       = 16;
  localparam int         BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
    ,
    VFY_ADDR,
    VFY_CMP
`endif
  } state_t;

endpackage

// File: rtl/picosoc_loader_packer.sv
// Byte-to-word packer for the firmware loader: tracks the byte lane,
// assembles little-endian 32-bit words and keeps the 8-bit payload sum.
// word/word_valid are combinational so the parent can register the write
// in the same cycle the fourth byte is accepted.
module picosoc_loader_packer
  import picosoc_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  sum
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane;
  logic [23:0] lanes_lo;

  // Lane counter, lower three lanes of the word, and running checksum.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane     <= 2'd0;
      lanes_lo <= 24'h0;
      sum      <= 8'h0;
    end else if (clear) begin
      lane <= 2'd0;
      sum  <= 8'h0;
    end else if (in_valid) begin
      lane <= lane + 2'd1;
      sum  <= sum + in_data;
      case (lane)
        2'd0:    lanes_lo[7:0]   <= in_data;
        2'd1:    lanes_lo[15:8]  <= in_data;
        2'd2:    lanes_lo[23:16] <= in_data;
        default: ;
      endcase
    end
  end

  assign word_valid = in_valid & (lane == LAST_LANE);
  assign word       = {in_data, lanes_lo};

endmodule

// File: rtl/picosoc_mem_loader.sv
// PicoSoC firmware RAM loader: parses SYNC, LEN_LO, LEN_HI, LEN*4 payload
// bytes, CSUM from a byte stream, writes words into RAM and holds the CPU
// in reset until a frame with a good checksum has been loaded.
// Define PICOSOC_MEM_LOADER_VERIFY_EN to read back and compare every word.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for the sync byte, other bytes dropped
// LEN_LO   | expecting low byte of the word count
// LEN_HI   | expecting high byte, range check against WORDS
// DATA     | collecting payload, one RAM write per four bytes
// CSUM     | expecting checksum byte, frame verdict
// VFY_ADDR | write cycle, then one read-address cycle (verify build)
// VFY_CMP  | compare read data with the written word (verify build)
module picosoc_mem_loader
  import picosoc_loader_pkg::*;
#(
  parameter int         WORDS     = 512,
  parameter int         ADDR_W    = 22,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_resetn
);

  localparam logic [LEN_FIELD_W-1:0] MAX_LEN = LEN_FIELD_W'(WORDS);
  localparam logic [LEN_FIELD_W-1:0] ONE     = LEN_FIELD_W'(1);

  state_t                  state, state_d;
  logic [7:0]              len_lo, len_lo_d;
  logic [LEN_FIELD_W-1:0]  len, len_d;
  logic [LEN_FIELD_W-1:0]  cnt, cnt_d;
  logic [LEN_FIELD_W-1:0]  len_rx;
  logic [3:0]              wen_d;
  logic [ADDR_W-1:0]       addr_d;
  logic [31:0]             wdata_d;
  logic                    busy_d, done_d, err_d, cpu_d;
  logic                    xfer;
  logic                    pk_clear, pk_valid, pk_word_valid;
  logic [31:0]             pk_word;
  logic [7:0]              pk_sum;

`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
  // last_q marks that the word under verify is the final one; a checksum
  // byte arriving during its write cycle is parked in held_byte_q.
  logic       rdy_q, rdy_d;
  logic       last_q, last_d;
  logic       held_q, held_d;
  logic [7:0] held_byte_q, held_byte_d;

  assign rx_ready = rdy_q;
`else
  logic [31:0] unused_rdata;

  assign unused_rdata = mem_rdata;
  assign rx_ready     = 1'b1;
`endif

  assign xfer   = rx_valid & rx_ready;
  assign len_rx = {rx_data, len_lo};

  picosoc_loader_packer u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (pk_clear),
    .in_valid   (pk_valid),
    .in_data    (rx_data),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .sum        (pk_sum)
  );

  // Next-state and next-output decode; every change rides on a transfer.
  always_comb begin
    state_d  = state;
    len_lo_d = len_lo;
    len_d    = len;
    cnt_d    = cnt;
    wen_d    = 4'h0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    busy_d   = busy;
    done_d   = done;
    err_d    = err;
    cpu_d    = cpu_resetn;
    pk_clear = 1'b0;
    pk_valid = 1'b0;
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
    rdy_d       = rdy_q;
    last_d      = last_q;
    held_d      = held_q;
    held_byte_d = held_byte_q;
`endif
    case (state)
      IDLE: begin
        if (xfer && rx_data == SYNC_BYTE) begin
          busy_d   = 1'b1;
          cpu_d    = 1'b0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          pk_clear = 1'b1;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d = len_rx;
          cnt_d = '0;
          if (len_rx > MAX_LEN) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (len_rx == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          pk_valid = 1'b1;
          if (pk_word_valid) begin
            wen_d   = 4'hF;
            addr_d  = ADDR_W'(cnt);
            wdata_d = pk_word;
            cnt_d   = cnt + ONE;
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
            last_d  = (cnt == len - ONE);
            held_d  = 1'b0;
            state_d = VFY_ADDR;
`else
            if (cnt == len - ONE) state_d = CSUM;
`endif
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (rx_data == pk_sum) begin
            done_d = 1'b1;
            cpu_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
      VFY_ADDR: begin
        if (mem_wen != 4'h0) begin
          // Write cycle: the port is still open for one more byte.
          rdy_d = 1'b0;
          if (xfer) begin
            if (last_q) begin
              held_d      = 1'b1;
              held_byte_d = rx_data;
            end else begin
              pk_valid = 1'b1;
            end
          end
        end else begin
          state_d = VFY_CMP;
        end
      end
      VFY_CMP: begin
        rdy_d = 1'b1;
        if (mem_rdata != mem_wdata) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!last_q) begin
          state_d = DATA;
        end else if (!held_q) begin
          state_d = CSUM;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (held_byte_q == pk_sum) begin
            done_d = 1'b1;
            cpu_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Registered outputs and frame bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_lo      <= 8'h0;
      len         <= '0;
      cnt         <= '0;
      mem_wen     <= 4'h0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cpu_resetn  <= 1'b1;
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
      rdy_q       <= 1'b1;
      last_q      <= 1'b0;
      held_q      <= 1'b0;
      held_byte_q <= 8'h0;
`endif
    end else begin
      len_lo      <= len_lo_d;
      len         <= len_d;
      cnt         <= cnt_d;
      mem_wen     <= wen_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      cpu_resetn  <= cpu_d;
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
      rdy_q       <= rdy_d;
      last_q      <= last_d;
      held_q      <= held_d;
      held_byte_q <= held_byte_d;
`endif
    end
  end

endmodule

// File: tb/tb_picosoc_mem_loader.sv
// Bench for picosoc_mem_loader: directed frames, a byte-position model of
// the frame format producing expected writes and flags, and literal pins.
module tb_picosoc_mem_loader;

  localparam int WORDS  = 512;
  localparam int ADDR_W = 22;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h0;
  logic              rx_ready;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy, done, err, cpu_resetn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picosoc_mem_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_resetn (cpu_resetn)
  );

  // RAM with registered read; optionally corrupts readback of word 1.
  logic [31:0] ram [WORDS];
  bit          corrupt_en = 1'b0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) ram[mem_addr[8:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= ram[mem_addr[8:0]] ^ ((corrupt_en && mem_addr == 22'd1) ? 32'h1 : 32'h0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: walks each accepted byte by its position in the frame.
  bit          m_in = 1'b0;
  int          m_pos = 0;
  int          m_len = 0;
  int          m_p;
  logic [7:0]  m_sum = 8'h0;
  logic [31:0] m_word = 32'h0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_cpu = 1'b1;
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_in = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cpu = 1'b1;
      exp_addr.delete();
      exp_data.delete();
    end else if (rx_valid && rx_ready) begin
      if (!m_in) begin
        if (rx_data == 8'hA5) begin
          m_in = 1'b1; m_pos = 0; m_sum = 8'h0;
          m_busy = 1'b1; m_cpu = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end
      end else begin
        m_pos++;
        if (m_pos == 1) begin
          m_len = int'(rx_data);
        end else if (m_pos == 2) begin
          m_len = m_len + int'(rx_data) * 256;
          if (m_len > WORDS) begin
            m_err = 1'b1; m_busy = 1'b0; m_in = 1'b0;
          end
        end else if (m_pos - 3 < 4 * m_len) begin
          m_p = m_pos - 3;
          m_word[8*(m_p%4) +: 8] = rx_data;
          m_sum = m_sum + rx_data;
          if (m_p % 4 == 3) begin
            exp_addr.push_back(m_p / 4);
            exp_data.push_back(m_word);
`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
            if (corrupt_en && m_p / 4 == 1) begin
              m_err = 1'b1; m_busy = 1'b0; m_in = 1'b0;
            end
`endif
          end
        end else begin
          m_in = 1'b0; m_busy = 1'b0;
          if (rx_data == m_sum) begin
            m_done = 1'b1; m_cpu = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every write against the model, flags every cycle.
  int          seen_addr[$];
  logic [31:0] seen_data[$];
  int          rdy_low = 0;

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_wen != 4'h0) begin
        seen_addr.push_back(int'(mem_addr));
        seen_data.push_back(mem_wdata);
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: wen %h addr %0d data %h, none expected", mem_wen, mem_addr, mem_wdata);
        end else begin
          check("write_wen", 32'(mem_wen), 32'hF);
          check("write_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
          check("write_data", mem_wdata, exp_data.pop_front());
        end
      end
      if (!rx_ready) rdy_low++;
`ifndef PICOSOC_MEM_LOADER_VERIFY_EN
      check("rx_ready", 32'(rx_ready), 32'd1);
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("cpu_resetn", 32'(cpu_resetn), 32'(m_cpu));
`endif
    end
  end

  task automatic send_bytes(input byte_q_t bq);
    foreach (bq[i]) begin
      int guard;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = bq[i];
      guard    = 0;
      while (!rx_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic new_test();
    seen_addr.delete();
    seen_data.delete();
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d, input logic e, input logic c);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'(c));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t fr;
    int      low0;

    // Reset values
    resetn = 1'b0;
    idle(3);
    check("rst_wen", 32'(mem_wen), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    idle(2);

    // Garbage bytes outside a frame
    new_test();
    fr = '{8'h00, 8'hFF};
    send_bytes(fr);
    idle(6);
    check("garbage_writes", 32'(seen_data.size()), 32'd0);
    check_flags("garbage", 1'b0, 1'b0, 1'b0, 1'b1);

    // Two-word frame, good checksum (0x11+..+0x88 = 0x264 -> 0x64)
    new_test();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    send_bytes(fr);
    idle(6);
    check("a_writes", 32'(seen_data.size()), 32'd2);
    check("a_w0_addr", 32'(seen_addr[0]), 32'd0);
    check("a_w0_data", seen_data[0], 32'h44332211);
    check("a_w1_addr", 32'(seen_addr[1]), 32'd1);
    check("a_w1_data", seen_data[1], 32'h88776655);
    check_flags("a", 1'b0, 1'b1, 1'b0, 1'b1);

    // Same frame, bad checksum
    new_test();
    fr[11] = 8'h00;
    send_bytes(fr);
    idle(6);
    check("badsum_writes", 32'(seen_data.size()), 32'd2);
    check_flags("badsum", 1'b0, 1'b0, 1'b1, 1'b0);

    // LEN = 513 rejected, then a good frame loads
    new_test();
    fr = '{8'hA5, 8'h01, 8'h02};
    send_bytes(fr);
    idle(6);
    check("len513_writes", 32'(seen_data.size()), 32'd0);
    check_flags("len513", 1'b0, 1'b0, 1'b1, 1'b0);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    send_bytes(fr);
    idle(6);
    check("after513_writes", 32'(seen_data.size()), 32'd2);
    check_flags("after513", 1'b0, 1'b1, 1'b0, 1'b1);

    // Sync byte inside payload is data (sum A5+01+02+03 = AB)
    new_test();
    fr = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hAB};
    send_bytes(fr);
    idle(6);
    check("sync_in_payload_writes", 32'(seen_data.size()), 32'd1);
    check("sync_in_payload_data", seen_data[0], 32'h030201A5);
    check_flags("sync_in_payload", 1'b0, 1'b1, 1'b0, 1'b1);

    // LEN = 0
    new_test();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_bytes(fr);
    idle(6);
    check("len0_writes", 32'(seen_data.size()), 32'd0);
    check_flags("len0", 1'b0, 1'b1, 1'b0, 1'b1);

    // LEN = WORDS, payload byte i = i mod 256, checksum 0
    new_test();
    fr = '{8'hA5, 8'h00, 8'h02};
    for (int i = 0; i < 4 * WORDS; i++) fr.push_back(8'(i));
    fr.push_back(8'h00);
    send_bytes(fr);
    idle(6);
    check("max_writes", 32'(seen_data.size()), 32'd512);
    check("max_last_addr", 32'(seen_addr[511]), 32'd511);
    check("max_last_data", seen_data[511], 32'hFFFEFDFC);
    check_flags("max", 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset asserted during a payload byte
    new_test();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(fr);
    check_flags("pre_abort", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    #2 resetn = 1'b0;
    #1;
    check("abort_wen", 32'(mem_wen), 32'h0);
    check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b1);
    rx_valid = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(2);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_bytes(fr);
    idle(6);
    check("abort_writes", 32'(seen_data.size()), 32'd0);
    check_flags("post_abort", 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef PICOSOC_MEM_LOADER_VERIFY_EN
    // Readback of word 1 corrupted: error after word 1, later bytes ignored
    new_test();
    corrupt_en = 1'b1;
    low0 = rdy_low;
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    send_bytes(fr);
    idle(6);
    check("vfy_rdy_low_cycles", 32'(rdy_low - low0), 32'd4);
    fr = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(fr);
    idle(6);
    check("vfy_writes", 32'(seen_data.size()), 32'd2);
    check_flags("vfy", 1'b0, 1'b0, 1'b1, 1'b0);
    corrupt_en = 1'b0;
`else
    low0 = rdy_low;
    check("rdy_never_low", 32'(low0), 32'd0);
`endif

    check("pending_writes", 32'(exp_addr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
